// File: rtl/packet_injector_pkg.sv
// Shared constants for the packet injector: packet field layout and FSM
// state encodings, imported by the injector top and its LFSR.
package packet_injector_pkg;

    localparam int PACKETWIDTH = 26;

    localparam int PID_MSB  = 24;
    localparam int PID_LSB  = 15;
    localparam int NID_MSB  = 14;
    localparam int NID_LSB  = 9;
    localparam int DATA_MSB = 8;

    localparam int PID_W  = PID_MSB - PID_LSB + 1;
    localparam int NID_W  = NID_MSB - NID_LSB + 1;
    localparam int DATA_W = DATA_MSB + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/packet_injector_lfsr9.sv
// 9-bit Fibonacci LFSR (taps 9 and 5) producing packet payloads.
// Ports: clk, reset (async active-low), advance (step once), value (state).
module lfsr9
    import packet_injector_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 9'h1A5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    // Tap 9 is value[8], tap 5 is value[4]; feedback shifts in at the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[DATA_W-2:0], value[8] ^ value[4]};
        end
    end

endmodule

// File: rtl/packet_injector.sv
// Traffic source for a router local port: builds packets, requests the
// router, waits for grant, then idles InjGap cycles before the next one.
// Ports: clk, reset (async active-low), Enable, DestID, InjGap, PktLimit,
// DnStrFull, GntDnStr in; PacketOut, ReqDnStr, PktCount, Done out.
module packet_injector
    import packet_injector_pkg::*;
#(
    parameter routerID                 = 6'b001_001,
    parameter int packetwidth          = PACKETWIDTH,
    parameter logic [DATA_W-1:0] LFSR_SEED = 9'h1A5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Enable,
    input  logic [NID_W-1:0]       DestID,
    input  logic [7:0]             InjGap,
    input  logic [9:0]             PktLimit,
    input  logic                   DnStrFull,
    input  logic                   GntDnStr,
    output logic [packetwidth-1:0] PacketOut,
    output logic                   ReqDnStr,
    output logic [9:0]             PktCount,
    output logic                   Done
);

    localparam int unsigned ROUTER_ID = routerID;

    // Catch unusable parameter overrides at elaboration.
    if (packetwidth < PACKETWIDTH || ROUTER_ID > 63 ||
        LFSR_SEED == '0) begin : g_param_check
        $error("packet_injector: illegal parameter override");
    end

    logic [1:0]             state;
    logic [7:0]             gap_cnt;
    logic [PID_W-1:0]       pkt_id;
    logic [DATA_W-1:0]      payload;
    logic                   grant;
    logic                   launch;
    logic [9:0]             count_next;
    logic [packetwidth-1:0] pkt_next;

    // Grants are only meaningful while a request is outstanding.
    assign grant      = (state == REQ) && GntDnStr;
    assign launch     = Enable && !DnStrFull && !Done;
    assign count_next = PktCount + 10'd1;

    always_comb begin
        pkt_next                   = '0;
        pkt_next[PID_MSB:PID_LSB]  = pkt_id;
        pkt_next[NID_MSB:NID_LSB]  = DestID;
        pkt_next[DATA_MSB:0]       = payload;
    end

    lfsr9 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .advance(grant),
        .value  (payload)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ReqDnStr  <= 1'b0;
            PacketOut <= '0;
            pkt_id    <= '0;
            PktCount  <= '0;
            Done      <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= REQ;
                        ReqDnStr  <= 1'b1;
                        PacketOut <= pkt_next;
                    end
                end
                REQ: begin
                    if (GntDnStr) begin
                        ReqDnStr <= 1'b0;
                        pkt_id   <= pkt_id + 1'b1;
                        PktCount <= count_next;
                        if (PktLimit != '0 && count_next == PktLimit) begin
                            Done <= 1'b1;
                        end
                        if (InjGap == '0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= InjGap;
                        end
                    end
                end
                GAP: begin
                    // Leave on the cycle the counter reaches zero.
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Directed testbench for packet_injector: reset, limit, hold, backpressure,
// gap timing, ID wrap and mid-request reset scenarios.
module tb_packet_injector;

    logic        clk;
    logic        reset;
    logic        Enable;
    logic [5:0]  DestID;
    logic [7:0]  InjGap;
    logic [9:0]  PktLimit;
    logic        DnStrFull;
    logic        GntDnStr;
    logic [25:0] PacketOut;
    logic        ReqDnStr;
    logic [9:0]  PktCount;
    logic        Done;

    int n_cmp;
    int n_bad;

    packet_injector dut (
        .clk      (clk),
        .reset    (reset),
        .Enable   (Enable),
        .DestID   (DestID),
        .InjGap   (InjGap),
        .PktLimit (PktLimit),
        .DnStrFull(DnStrFull),
        .GntDnStr (GntDnStr),
        .PacketOut(PacketOut),
        .ReqDnStr (ReqDnStr),
        .PktCount (PktCount),
        .Done     (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset with all inputs quiet; returns at a falling edge, out of reset.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        Enable    = 1'b0;
        DnStrFull = 1'b0;
        GntDnStr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        Enable    = 1'b1;
        DestID    = 6'b001_010;
        InjGap    = 8'd0;
        PktLimit  = 10'd0;
        DnStrFull = 1'b0;
        GntDnStr  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ReqDnStr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req got=%b exp=0", ReqDnStr);
        end
        n_cmp++;
        if (PacketOut !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_pkt got=%h exp=0", PacketOut);
        end
        n_cmp++;
        if (PktCount !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_cnt got=%0d exp=0", PktCount);
        end
        n_cmp++;
        if (Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done got=%b exp=0", Done);
        end
    endtask

    task automatic test_limit();
        logic [25:0] exp_pkt [3];
        exp_pkt[0] = {1'b0, 10'd0, 6'b001_010, 9'h1A5};
        exp_pkt[1] = {1'b0, 10'd1, 6'b001_010, 9'h14B};
        exp_pkt[2] = {1'b0, 10'd2, 6'b001_010, 9'h097};
        do_reset();
        DestID   = 6'b001_010;
        InjGap   = 8'd0;
        PktLimit = 10'd3;
        Enable   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ReqDnStr !== 1'b1 || PacketOut !== exp_pkt[i]) begin
                n_bad++;
                $display("FAIL limit_pkt%0d got req=%b pkt=%h exp req=1 pkt=%h",
                         i, ReqDnStr, PacketOut, exp_pkt[i]);
            end
            GntDnStr = 1'b1;
            @(negedge clk);
            GntDnStr = 1'b0;
            n_cmp++;
            if (ReqDnStr !== 1'b0 || PktCount !== 10'(i + 1)) begin
                n_bad++;
                $display("FAIL limit_grant%0d got req=%b cnt=%0d exp req=0 cnt=%0d",
                         i, ReqDnStr, PktCount, i + 1);
            end
        end
        n_cmp++;
        if (Done !== 1'b1) begin
            n_bad++;
            $display("FAIL limit_done got=%b exp=1", Done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ReqDnStr !== 1'b0 || Done !== 1'b1 || PktCount !== 10'd3) begin
                n_bad++;
                $display("FAIL limit_stop%0d got req=%b done=%b cnt=%0d exp 0 1 3",
                         i, ReqDnStr, Done, PktCount);
            end
        end
    endtask

    task automatic test_hold();
        logic [25:0] exp_pkt;
        exp_pkt = {1'b0, 10'd0, 6'b001_001, 9'h1A5};
        do_reset();
        DestID   = 6'b001_001;
        InjGap   = 8'd0;
        PktLimit = 10'd0;
        Enable   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (ReqDnStr !== 1'b1 || PacketOut !== exp_pkt) begin
                n_bad++;
                $display("FAIL hold%0d got req=%b pkt=%h exp req=1 pkt=%h",
                         i, ReqDnStr, PacketOut, exp_pkt);
            end
            Enable    = ~Enable;
            DnStrFull = i[1];
            @(negedge clk);
        end
        Enable    = 1'b0;
        DnStrFull = 1'b0;
        GntDnStr  = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        n_cmp++;
        if (ReqDnStr !== 1'b0 || PktCount !== 10'd1) begin
            n_bad++;
            $display("FAIL hold_grant got req=%b cnt=%0d exp req=0 cnt=1",
                     ReqDnStr, PktCount);
        end
    endtask

    task automatic test_full();
        do_reset();
        DestID    = 6'b000_011;
        InjGap    = 8'd0;
        PktLimit  = 10'd0;
        DnStrFull = 1'b1;
        Enable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ReqDnStr !== 1'b0) begin
                n_bad++;
                $display("FAIL full%0d got req=%b exp=0", i, ReqDnStr);
            end
        end
        DnStrFull = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ReqDnStr !== 1'b1) begin
            n_bad++;
            $display("FAIL full_release got req=%b exp=1", ReqDnStr);
        end
    endtask

    task automatic test_gap();
        logic [25:0] exp_pkt;
        exp_pkt = {1'b0, 10'd1, 6'b010_100, 9'h14B};
        do_reset();
        DestID   = 6'b010_100;
        InjGap   = 8'd5;
        PktLimit = 10'd0;
        Enable   = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        // Five GAP cycles plus the IDLE cycle are quiet.
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (ReqDnStr !== 1'b0) begin
                n_bad++;
                $display("FAIL gap%0d got req=%b exp=0", i, ReqDnStr);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ReqDnStr !== 1'b1 || PacketOut !== exp_pkt) begin
            n_bad++;
            $display("FAIL gap_next got req=%b pkt=%h exp req=1 pkt=%h",
                     ReqDnStr, PacketOut, exp_pkt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        DestID   = 6'b100_001;
        InjGap   = 8'd0;
        PktLimit = 10'd0;
        Enable   = 1'b1;
        GntDnStr = 1'b1;
        // Grant held high: one packet every two cycles, 1024 after 2048.
        repeat (2048) @(negedge clk);
        n_cmp++;
        if (PktCount !== 10'd0 || Done !== 1'b0 || ReqDnStr !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_1024 got cnt=%0d done=%b req=%b exp 0 0 0",
                     PktCount, Done, ReqDnStr);
        end
        @(negedge clk);
        n_cmp++;
        if (ReqDnStr !== 1'b1 || PacketOut[24:15] !== 10'd0) begin
            n_bad++;
            $display("FAIL wrap_pid got req=%b pid=%0d exp req=1 pid=0",
                     ReqDnStr, PacketOut[24:15]);
        end
        @(negedge clk);
        GntDnStr = 1'b0;
        n_cmp++;
        if (PktCount !== 10'd1 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_1025 got cnt=%0d done=%b exp cnt=1 done=0",
                     PktCount, Done);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] exp_pkt;
        exp_pkt = {1'b0, 10'd0, 6'b000_111, 9'h1A5};
        do_reset();
        DestID   = 6'b000_111;
        InjGap   = 8'd0;
        PktLimit = 10'd0;
        Enable   = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ReqDnStr !== 1'b1 || PacketOut[24:15] !== 10'd1) begin
            n_bad++;
            $display("FAIL mid_setup got req=%b pid=%0d exp req=1 pid=1",
                     ReqDnStr, PacketOut[24:15]);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ReqDnStr !== 1'b0 || PktCount !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_async got req=%b cnt=%0d exp req=0 cnt=0",
                     ReqDnStr, PktCount);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ReqDnStr !== 1'b1 || PacketOut !== exp_pkt) begin
            n_bad++;
            $display("FAIL mid_first got req=%b pkt=%h exp req=1 pkt=%h",
                     ReqDnStr, PacketOut, exp_pkt);
        end
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        n_cmp++;
        if (PktCount !== 10'd1) begin
            n_bad++;
            $display("FAIL mid_count got=%0d exp=1", PktCount);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_limit();
        test_hold();
        test_full();
        test_gap();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
